trace_replay_encoder: RTL and testbench

- Inverse of the per-channel spike tracer: takes a snapshot of p_channels decaying trace values and regenerates the spike events that produced them.
- Relative timing and chronological order are preserved (oldest event first).
- Sits between trace memory / readout and any downstream spiking layer that needs a spike train instead of time-surface values: replay, debug, regeneration of input to a next layer.
- Single-snapshot engine with a valid/ready input handshake and a done pulse.

---
 rtl/trace_replay_encoder.sv | 68 ++++++
 tb/tb_trace_replay_encoder.sv | 107 ++++++++++
 2 files changed

// File: rtl/trace_replay_encoder.sv
// trace_replay_encoder: replays a snapshot of decaying traces as spike pulses, oldest event first.
module trace_replay_encoder #(
  parameter int p_width    = 8,
  parameter int p_channels = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [p_channels*p_width-1:0] i_trace,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic [p_channels-1:0]         o_spike,
  output logic                          o_busy,
  output logic                          o_done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [p_width-1:0] MAX = '1;
  state_t                        r_state;
  logic [p_width-1:0]            r_cnt;
  logic [p_channels*p_width-1:0] r_trace;
  logic [p_width-1:0]            w_next;
  logic [p_channels-1:0]         w_hit;
  assign w_next = r_cnt + 1'b1;
  // w_next only spans 1..MAX while counting, so a zero trace can never match
  for (genvar k = 0; k < p_channels; k++) begin : g_hit
    assign w_hit[k] = r_trace[k*p_width +: p_width] == w_next;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_trace <= '0;
      o_spike <= '0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_ready <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          o_spike <= '0;
          r_cnt   <= '0;
          if (i_valid) begin
            r_trace <= i_trace;
            r_state <= RUN;
            o_ready <= 1'b0;
            o_busy  <= 1'b1;
          end
        end
        RUN: begin
          if (r_cnt == MAX) begin
            r_state <= DONE;
            o_spike <= '0;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
          end else begin
            r_cnt   <= w_next;
            o_spike <= w_hit;
          end
        end
        DONE: begin
          r_state <= IDLE;
          o_done  <= 1'b0;
          o_ready <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_trace_replay_encoder.sv
// tb_trace_replay_encoder: directed and random stimulus against a replay-schedule reference model.
module tb_trace_replay_encoder;
  localparam int W = 4;
  localparam int C = 4;
  localparam int MAX = 15;
  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           valid = 1'b0;
  logic [C*W-1:0] trace = '0;
  logic           ready, busy, done;
  logic [C-1:0]   spike;
  int             checks = 0;
  int             failures = 0;
  int             cyc = 0;
  bit             m_active = 1'b0;
  bit             m_ready = 1'b1;
  int             m_age = 0;
  int             m_tr [C];

  trace_replay_encoder #(.p_width(W), .p_channels(C)) dut (
    .i_clk(clk), .i_rst(rst), .i_trace(trace), .i_valid(valid),
    .o_ready(ready), .o_spike(spike), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // model: a snapshot accepted at edge E0 is described purely by its age in edges since E0
  task automatic step(input logic r, input logic v, input logic [C*W-1:0] t);
    logic [C-1:0] exp_spike;
    rst = r; valid = v; trace = t;
    @(posedge clk);
    cyc++;
    if (r) begin
      m_active = 1'b0;
    end else if (m_ready && v) begin
      m_active = 1'b1;
      m_age = 0;
      for (int k = 0; k < C; k++) m_tr[k] = int'(t[k*W +: W]);
    end else if (m_active) begin
      m_age++;
      if (m_age > MAX + 1) m_active = 1'b0;
    end
    m_ready = !m_active;
    exp_spike = '0;
    for (int k = 0; k < C; k++)
      exp_spike[k] = m_active && m_age >= 1 && m_age <= MAX && m_tr[k] == m_age;
    #1;
    chk("ready", 32'(ready), 32'(m_ready));
    chk("busy",  32'(busy),  32'(m_active && m_age <= MAX));
    chk("done",  32'(done),  32'(m_active && m_age == MAX + 1));
    chk("spike", 32'(spike), 32'(exp_spike));
  endtask

  function automatic logic [C*W-1:0] pack(input int a, input int b, input int c, input int d);
    return {4'(d), 4'(c), 4'(b), 4'(a)};
  endfunction

  initial begin
    int seen;
    step(1, 0, '0);
    step(1, 0, '0);
    step(0, 0, '0);
    step(0, 1, pack(15, 1, 8, 0));
    for (int i = 0; i < 20; i++) step(0, 0, '0);
    step(0, 1, pack(5, 5, 5, 5));
    for (int i = 0; i < 19; i++) step(0, 0, '0);
    step(0, 1, pack(0, 0, 0, 0));
    for (int i = 0; i < 19; i++) step(0, 0, '0);
    step(0, 1, pack(3, 6, 9, 12));
    step(0, 0, '0);
    step(0, 0, '0);
    for (int i = 0; i < 40; i++) step(0, 1, pack(2, 7, 11, 14));
    for (int i = 0; i < 20; i++) step(0, 0, '0);
    step(0, 1, pack(10, 12, 14, 15));
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, '0);
      if (spike[0]) seen++;
    end
    chk("mid_spike10", 32'(seen), 32'd1);
    step(1, 0, '0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, '0);
      if (spike != '0 || done) seen++;
    end
    chk("post_reset_quiet", 32'(seen), 32'd0);
    seen = 0;
    for (int i = 0; i < 3 * (MAX + 3); i++) begin
      step(0, 1, pack(1, 2, 3, 4));
      if (done) seen++;
    end
    chk("b2b_done_count", 32'(seen), 32'd3);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(199) == 0, $urandom_range(2) == 0, 16'($urandom));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
